// File: rtl/fp_tamsayi_cevirme.sv
`default_nettype none
// ============================================================================
// Module   : fp_tamsayi_cevirme
// Desc     : IEEE-754 float to W-bit signed integer converter with a
//            one-bit-per-cycle aligner. Define FP_TAMSAYI_YUVARLAMA_EN for
//            round-to-nearest-even; otherwise the result truncates toward zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp_tamsayi_cevirme #(
    parameter int b = 32,
    parameter int e = 8,
    parameter int m = 23,
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         gecerli_i,
    input  logic [b-1:0] sayi_i,
    output logic         hazir_o,
    output logic         gecerli_o,
    input  logic         alici_hazir_i,
    output logic [W-1:0] sonuc_o,
    output logic         tasma_o,
    output logic         gecersiz_o
);

    // Accumulator holds either the widest left-aligned integer or the raw significand.
    localparam int AW     = (m + 1 > W) ? m + 1 : W;
    localparam int NW     = $clog2(AW + 1);
    localparam int c_bias = (1 << (e - 1)) - 1;

    localparam logic [AW:0]  c_max_pos = {{(AW + 2 - W){1'b0}}, {(W - 1){1'b1}}};
    localparam logic [AW:0]  c_max_neg = (AW + 1)'(1) << (W - 1);
    localparam logic [W-1:0] c_sat_pos = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] c_sat_neg = {1'b1, {(W - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_SHIFT  = 3'd2,
        S_FINAL  = 3'd3,
        S_OUT    = 3'd4
    } durum_t;

    durum_t         durum_q, durum_d;
    logic [b-1:0]   sayi_q, sayi_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [NW-1:0]  n_q, n_d;
    logic           sol_q, sol_d;
    logic           hazir_q, hazir_d;
    logic           gecerli_q, gecerli_d;
    logic [W-1:0]   sonuc_q, sonuc_d;
    logic           tasma_q, tasma_d;
    logic           gecersiz_q, gecersiz_d;
`ifdef FP_TAMSAYI_YUVARLAMA_EN
    logic           guard_q, guard_d;
    logic           sticky_q, sticky_d;
`endif

    logic               w_isaret;
    logic [e-1:0]       w_us;
    logic [m-1:0]       w_man;
    logic               w_us_dolu;
    logic               w_us_sifir;
    logic               w_man_sifir;
    logic signed [31:0] w_k;
    logic               w_buyuk;
    logic               w_sol;
    logic [NW-1:0]      w_n;
    logic               w_inc;
    logic [AW:0]        w_mag;
    logic [W-1:0]       w_mag_w;
    logic [W-1:0]       w_neg;
    logic               w_tasma_son;

    assign w_isaret    = sayi_q[b-1];
    assign w_us        = sayi_q[b-2:m];
    assign w_man       = sayi_q[m-1:0];
    assign w_us_dolu   = &w_us;
    assign w_us_sifir  = ~|w_us;
    assign w_man_sifir = ~|w_man;
    assign w_k         = $signed(32'(w_us)) - c_bias;

    // -2^(W-1) is the only representable value with k = W-1.
    assign w_buyuk = (w_k > (W - 1)) ||
                     ((w_k == (W - 1)) && !(w_isaret && w_man_sifir));
    assign w_sol   = (w_k >= m);
    assign w_n     = w_sol ? NW'(w_k - m) : NW'(m - w_k);

`ifdef FP_TAMSAYI_YUVARLAMA_EN
    assign w_inc = guard_q & (sticky_q | acc_q[0]);
`else
    assign w_inc = 1'b0;
`endif

    assign w_mag       = {1'b0, acc_q} + (AW + 1)'(w_inc);
    assign w_mag_w     = w_mag[W-1:0];
    assign w_neg       = -w_mag_w;
    assign w_tasma_son = w_isaret ? (w_mag > c_max_neg) : (w_mag > c_max_pos);

    always_comb begin
        durum_d    = durum_q;
        sayi_d     = sayi_q;
        acc_d      = acc_q;
        n_d        = n_q;
        sol_d      = sol_q;
        hazir_d    = 1'b0;
        gecerli_d  = 1'b0;
        sonuc_d    = sonuc_q;
        tasma_d    = tasma_q;
        gecersiz_d = gecersiz_q;
`ifdef FP_TAMSAYI_YUVARLAMA_EN
        guard_d    = guard_q;
        sticky_d   = sticky_q;
`endif
        case (durum_q)
            S_IDLE: begin
                hazir_d = 1'b1;
                if (gecerli_i) begin
                    sayi_d     = sayi_i;
                    tasma_d    = 1'b0;
                    gecersiz_d = 1'b0;
                    hazir_d    = 1'b0;
                    durum_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                durum_d = S_OUT;
`ifdef FP_TAMSAYI_YUVARLAMA_EN
                guard_d  = 1'b0;
                sticky_d = 1'b0;
`endif
                if (w_us_dolu && !w_man_sifir) begin
                    sonuc_d    = '0;
                    gecersiz_d = 1'b1;
                end else if (w_us_dolu || w_buyuk) begin
                    sonuc_d = w_isaret ? c_sat_neg : c_sat_pos;
                    tasma_d = 1'b1;
                end else if (w_us_sifir) begin
                    sonuc_d = '0;
                end else if (w_k < 0) begin
                    acc_d   = '0;
                    durum_d = S_FINAL;
`ifdef FP_TAMSAYI_YUVARLAMA_EN
                    // k = -1 puts the hidden bit exactly at the half position.
                    guard_d  = (w_k == -1);
                    sticky_d = (w_k != -1) || !w_man_sifir;
`endif
                end else begin
                    acc_d   = AW'({1'b1, w_man});
                    sol_d   = w_sol;
                    n_d     = w_n;
                    durum_d = (w_n == '0) ? S_FINAL : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (sol_q) begin
                    acc_d = acc_q << 1;
                end else begin
                    acc_d = acc_q >> 1;
`ifdef FP_TAMSAYI_YUVARLAMA_EN
                    guard_d  = acc_q[0];
                    sticky_d = sticky_q | guard_q;
`endif
                end
                n_d = n_q - NW'(1);
                if (n_q == NW'(1)) begin
                    durum_d = S_FINAL;
                end
            end
            S_FINAL: begin
                durum_d = S_OUT;
                if (w_tasma_son) begin
                    sonuc_d = w_isaret ? c_sat_neg : c_sat_pos;
                    tasma_d = 1'b1;
                end else begin
                    sonuc_d = w_isaret ? w_neg : w_mag_w;
                end
            end
            S_OUT: begin
                // First OUT cycle raises gecerli_o; the handshake is only seen after that.
                if (gecerli_q && alici_hazir_i) begin
                    durum_d = S_IDLE;
                    hazir_d = 1'b1;
                end else begin
                    gecerli_d = 1'b1;
                end
            end
            default: begin
                durum_d = S_IDLE;
                hazir_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q    <= S_IDLE;
            sayi_q     <= '0;
            acc_q      <= '0;
            n_q        <= '0;
            sol_q      <= 1'b0;
            hazir_q    <= 1'b1;
            gecerli_q  <= 1'b0;
            sonuc_q    <= '0;
            tasma_q    <= 1'b0;
            gecersiz_q <= 1'b0;
`ifdef FP_TAMSAYI_YUVARLAMA_EN
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
`endif
        end else begin
            durum_q    <= durum_d;
            sayi_q     <= sayi_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            sol_q      <= sol_d;
            hazir_q    <= hazir_d;
            gecerli_q  <= gecerli_d;
            sonuc_q    <= sonuc_d;
            tasma_q    <= tasma_d;
            gecersiz_q <= gecersiz_d;
`ifdef FP_TAMSAYI_YUVARLAMA_EN
            guard_q    <= guard_d;
            sticky_q   <= sticky_d;
`endif
        end
    end

    assign hazir_o    = hazir_q;
    assign gecerli_o  = gecerli_q;
    assign sonuc_o    = sonuc_q;
    assign tasma_o    = tasma_q;
    assign gecersiz_o = gecersiz_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_tamsayi_cevirme.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_tamsayi_cevirme
// Desc     : Directed and random float-to-int conversions against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_tamsayi_cevirme;

    logic        clk;
    logic        rst_i;
    logic        gecerli_i;
    logic [31:0] sayi_i;
    logic        hazir_o;
    logic        gecerli_o;
    logic        alici_hazir_i;
    logic [31:0] sonuc_o;
    logic        tasma_o;
    logic        gecersiz_o;

    int kontrol = 0;
    int hata    = 0;

    fp_tamsayi_cevirme dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .gecerli_i     (gecerli_i),
        .sayi_i        (sayi_i),
        .hazir_o       (hazir_o),
        .gecerli_o     (gecerli_o),
        .alici_hazir_i (alici_hazir_i),
        .sonuc_o       (sonuc_o),
        .tasma_o       (tasma_o),
        .gecersiz_o    (gecersiz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        kontrol++;
        assert (obs === exp) else begin
            hata++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value = 1.M * 2^k; integer part by exact division, optional half-even rounding.
    task automatic model(input logic [31:0] f, output logic [31:0] r,
                         output logic t, output logic g, output int lat);
        logic   s;
        int     ex;
        int     k;
        int     d;
        longint man;
        longint sc;
        longint q;
        longint mag;
`ifdef FP_TAMSAYI_YUVARLAMA_EN
        longint rem;
        longint half;
`endif
        s   = f[31];
        ex  = int'(f[30:23]);
        man = longint'(f[22:0]);
        k   = ex - 127;
        r   = 32'h0;
        t   = 1'b0;
        g   = 1'b0;
        lat = 2;
        if (ex == 255) begin
            if (man != 0) g = 1'b1;
            else begin
                t = 1'b1;
                r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else if (ex == 0) begin
            r = 32'h0;
        end else if (k > 31 || (k == 31 && !(s && man == 0))) begin
            t = 1'b1;
            r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            sc  = man + 64'sd8388608;
            lat = (k < 0) ? 3 : ((k >= 23) ? 3 + k - 23 : 3 + 23 - k);
            if (k >= 23) begin
                mag = sc * (64'sd1 <<< (k - 23));
            end else begin
                d = 23 - k;
                if (d > 62) mag = 0;
                else begin
                    q   = sc / (64'sd1 <<< d);
                    mag = q;
`ifdef FP_TAMSAYI_YUVARLAMA_EN
                    rem  = sc - q * (64'sd1 <<< d);
                    half = (64'sd1 <<< d) / 2;
                    if (rem > half || (rem == half && (q % 2) == 1)) mag = q + 1;
`endif
                end
            end
            if (!s && mag > 64'sd2147483647) begin
                t = 1'b1;
                r = 32'h7FFF_FFFF;
            end else if (s && mag > 64'sd2147483648) begin
                t = 1'b1;
                r = 32'h8000_0000;
            end else begin
                r = s ? 32'(-mag) : 32'(mag);
            end
        end
    endtask

    task automatic islem(input logic [31:0] f, input int tut);
        logic [31:0] r_exp;
        logic        t_exp;
        logic        g_exp;
        int          lat;
        int          cyc;
        int          mesgul_hata;
        int          tut_hata;
        model(f, r_exp, t_exp, g_exp, lat);
        @(negedge clk);
        alici_hazir_i = (tut == 0);
        chk($sformatf("ready_before_%h", f), 64'(hazir_o), 64'd1);
        gecerli_i = 1'b1;
        sayi_i    = f;
        @(posedge clk);
        #1;
        gecerli_i   = 1'b0;
        sayi_i      = $urandom;
        cyc         = 0;
        mesgul_hata = 0;
        while (gecerli_o !== 1'b1 && cyc < 200) begin
            if (hazir_o !== 1'b0) mesgul_hata++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk($sformatf("latency_%h", f), 64'(cyc), 64'(lat));
        chk($sformatf("busy_ready_%h", f), 64'(mesgul_hata), 64'd0);
        chk($sformatf("result_%h", f), 64'(sonuc_o), 64'(r_exp));
        chk($sformatf("flags_%h", f), 64'({tasma_o, gecersiz_o}), 64'({t_exp, g_exp}));
        if (tut > 0) begin
            tut_hata = 0;
            for (int i = 0; i < tut; i++) begin
                @(negedge clk);
                gecerli_i = 1'b1;
                sayi_i    = $urandom;
                @(posedge clk);
                #1;
                if (gecerli_o !== 1'b1 || hazir_o !== 1'b0 || sonuc_o !== r_exp ||
                    tasma_o !== t_exp || gecersiz_o !== g_exp) tut_hata++;
            end
            chk($sformatf("hold_stable_%h", f), 64'(tut_hata), 64'd0);
        end
        @(negedge clk);
        gecerli_i     = 1'b0;
        alici_hazir_i = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("handshake_%h", f), 64'({gecerli_o, hazir_o}), 64'b01);
    endtask

    initial begin
        logic [31:0] f;
        logic [7:0]  ex;
        rst_i         = 1'b1;
        gecerli_i     = 1'b0;
        sayi_i        = 32'h0;
        alici_hazir_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'({hazir_o, gecerli_o, sonuc_o, tasma_o, gecersiz_o}),
            64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0}));
        @(negedge clk);
        rst_i = 1'b0;

        islem(32'h3F80_0000, 0);
        islem(32'hC2F6_E666, 0);
        islem(32'h4F00_0000, 0);
        islem(32'hCF00_0000, 0);
        islem(32'h3FC0_0000, 0);
        islem(32'h4020_0000, 0);
        islem(32'h3F00_0000, 0);
        islem(32'h3F40_0000, 0);
        islem(32'h3F7F_FFFF, 0);
        islem(32'h7FC0_0000, 0);
        islem(32'hFF80_0000, 0);
        islem(32'h0000_0000, 0);
        islem(32'h8000_0000, 0);
        islem(32'h4EFF_FFFF, 0);
        islem(32'h3FC0_0000, 5);

        // Abort a conversion while it is shifting.
        @(negedge clk);
        gecerli_i = 1'b1;
        sayi_i    = 32'h3F80_0000;
        @(posedge clk);
        #1;
        gecerli_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_shift", 64'({hazir_o, gecerli_o, sonuc_o}), 64'({1'b1, 1'b0, 32'h0}));
        @(negedge clk);
        rst_i = 1'b0;

        for (int i = 0; i < 40; i++) begin
            case (i % 8)
                0:       ex = 8'd0;
                1:       ex = 8'd255;
                2:       ex = 8'(157 + $urandom_range(0, 1));
                default: ex = 8'($urandom_range(100, 160));
            endcase
            f = {1'($urandom_range(0, 1)), ex, 23'($urandom)};
            islem(f, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", kontrol, hata);
        $finish;
    end

endmodule

`default_nettype wire
